kadai3_host_driver: RTL and testbench

- Host-side master for the two-FIFO multiply pipeline; drives the opposite end of its FIFO interface.
- On START it writes COUNT packed operand pairs {a[7:0], b[7:0]} into the input FIFO, honouring FULL.
- Concurrently it drains the same number of 16-bit products from the output FIFO, honouring EMPTY/VALID.
- It accumulates the products and, optionally, checks each one against a locally regenerated expected value.

---
 rtl/kadai3_host_driver.sv | 147 ++++++++++++++
 tb/tb_kadai3_host_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kadai3_host_driver.sv
// rtl/kadai3_host_driver.sv - host-side master for the two-FIFO multiply pipeline
//
// Purpose: on START, writes COUNT operand pairs {a,b} into the input FIFO and
// concurrently drains COUNT 16-bit products from the output FIFO, accumulating
// them into SUM. With KADAI3_HOST_CHECK_EN defined, each received product is
// also compared against a locally regenerated expected value (ERR_CNT).
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   START           single-cycle run request, sampled only in IDLE
//   COUNT           number of pairs, latched on accepted START
//   A_BASE, B_BASE  first a / b operands, latched on accepted START
//   WR, DIN, FULL   input-FIFO write strobe, data {a,b}, full flag
//   RD, DOUT        output-FIFO read strobe and product data
//   EMPTY, VALID    output-FIFO empty flag, DOUT valid (cycle after RD)
//   BUSY, DONE      run in progress, one-cycle completion pulse
//   SUM             modulo-2^SUM_W sum of received products
//   ERR_CNT         saturating count of product mismatches
//
// Optional feature macro: KADAI3_HOST_CHECK_EN (expected-value comparator).

module kadai3_host_driver #(
  parameter int CNT_W = 8,
  parameter int SUM_W = 32,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  input  logic [7:0]       A_BASE,
  input  logic [7:0]       B_BASE,
  output logic             WR,
  output logic [15:0]      DIN,
  input  logic             FULL,
  output logic             RD,
  input  logic [15:0]      DOUT,
  input  logic             EMPTY,
  input  logic             VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic [SUM_W-1:0] SUM,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, wr_cnt, iss_cnt, rcv_cnt;
  logic [7:0]       a_base, b_base;
  logic [7:0]       wr_off;
  logic             start_ok, wr_go, rcv_ok, rcv_last;

  // Operands wrap modulo 256, so only the low byte of the counter matters.
  assign wr_off = 8'(wr_cnt);

  always_comb begin
    start_ok = (state == S_IDLE) && START;
    wr_go    = (state == S_RUN) && (wr_cnt < cnt) && !FULL;
    // A VALID arriving after all COUNT results are in is spurious and dropped.
    rcv_ok   = (state == S_RUN) && VALID && (rcv_cnt < cnt);
    rcv_last = rcv_ok && ((rcv_cnt + CNT_ONE) == cnt);
    // RD is combinational from EMPTY so a one-entry FIFO is never over-read.
    RD       = (state == S_RUN) && !EMPTY && (iss_cnt < cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = (COUNT == '0) ? S_FIN : S_RUN;
      S_RUN:   if (rcv_last) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_base  <= '0;
      b_base  <= '0;
      wr_cnt  <= '0;
      iss_cnt <= '0;
      rcv_cnt <= '0;
      WR      <= 1'b0;
      DIN     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      SUM     <= '0;
    end else begin
      state <= state_nxt;
      WR    <= wr_go;
      DONE  <= (state == S_FIN);
      if (start_ok) begin
        cnt     <= COUNT;
        a_base  <= A_BASE;
        b_base  <= B_BASE;
        wr_cnt  <= '0;
        iss_cnt <= '0;
        rcv_cnt <= '0;
        SUM     <= '0;
        BUSY    <= 1'b1;
      end else if (state == S_FIN) begin
        BUSY <= 1'b0;
      end
      if (wr_go) begin
        DIN    <= {a_base + wr_off, b_base + wr_off};
        wr_cnt <= wr_cnt + CNT_ONE;
      end
      if (RD) iss_cnt <= iss_cnt + CNT_ONE;
      if (rcv_ok) begin
        SUM     <= SUM + SUM_W'(DOUT);
        rcv_cnt <= rcv_cnt + CNT_ONE;
      end
    end
  end

`ifdef KADAI3_HOST_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [7:0]  exp_a, exp_b;
  logic [15:0] exp_prod;

  // Results return in write order, so the receive index regenerates the operands.
  always_comb begin
    exp_a    = a_base + 8'(rcv_cnt);
    exp_b    = b_base + 8'(rcv_cnt);
    exp_prod = 16'(exp_a) * 16'(exp_b);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ERR_CNT <= '0;
    end else if (start_ok) begin
      ERR_CNT <= '0;
    end else if (rcv_ok && (DOUT != exp_prod) && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + ERR_ONE;
    end
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_kadai3_host_driver.sv
// tb/tb_kadai3_host_driver.sv - self-checking bench for kadai3_host_driver

module tb_kadai3_host_driver;

  logic        CLK = 1'b0;
  logic        RST, START, FULL;
  logic [7:0]  COUNT, A_BASE, B_BASE;
  logic        WR, RD, BUSY, DONE;
  logic [15:0] DIN, DOUT;
  logic        EMPTY, VALID;
  logic [31:0] SUM;
  logic [7:0]  ERR_CNT;

  kadai3_host_driver dut (
    .CLK(CLK), .RST(RST), .START(START), .COUNT(COUNT),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .WR(WR), .DIN(DIN), .FULL(FULL),
    .RD(RD), .DOUT(DOUT), .EMPTY(EMPTY), .VALID(VALID), .BUSY(BUSY),
    .DONE(DONE), .SUM(SUM), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef KADAI3_HOST_CHECK_EN
  localparam int CORRUPT_ERR = 1;
`else
  localparam int CORRUPT_ERR = 0;
`endif

  typedef struct {
    int          cnt;
    int          a;
    int          b;
    int          full_at;
    int          full_len;
    int          corrupt;
    int          exp_sum;
    int          exp_err;
    int          exp_wr;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // Pipeline model: product queue standing in for both FIFOs plus multiplier.
  logic [15:0] pq[$];
  logic        rd_seen = 1'b0, wr_seen = 1'b0;
  logic [15:0] din_seen = '0;
  logic [15:0] prod;
  int          push_idx = 0;
  int          corrupt_sel = -1;

  int          n_wr = 0, n_rd = 0, done_cnt = 0, full_viol = 0;
  logic        full_at_pos = 1'b0;
  logic [15:0] first_din = '0, last_din = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    rd_seen  = RD;
    wr_seen  = WR;
    din_seen = DIN;
    if (WR) begin
      if (n_wr == 0) first_din = DIN;
      last_din = DIN;
      n_wr++;
      if (full_at_pos) full_viol++;
    end
    if (RD) n_rd++;
    if (DONE) done_cnt++;
  end

  always @(posedge CLK) begin
    full_at_pos = FULL;
    #1;
    if (!RST) begin
      pq.delete();
      VALID = 1'b0;
      EMPTY = 1'b1;
      DOUT  = '0;
    end else begin
      VALID = rd_seen;
      if (rd_seen && pq.size() > 0) DOUT = pq.pop_front();
      if (wr_seen) begin
        prod = 16'(din_seen[15:8]) * 16'(din_seen[7:0]);
        if (push_idx == corrupt_sel) prod = 16'h0005;
        pq.push_back(prod);
        push_idx++;
      end
      EMPTY = (pq.size() == 0);
    end
  end

  task automatic run_case(input int idx);
    vec_t v;
    int   cyc;
    v = vecs[idx];
    n_wr = 0; n_rd = 0; done_cnt = 0; full_viol = 0; push_idx = 0;
    corrupt_sel = v.corrupt;
    @(negedge CLK); #1;
    COUNT = 8'(v.cnt); A_BASE = 8'(v.a); B_BASE = 8'(v.b); START = 1'b1;
    @(negedge CLK); #1;
    START = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge CLK); #1;
      cyc++;
      if (cyc == v.full_at) FULL = 1'b1;
      if (cyc == v.full_at + v.full_len) FULL = 1'b0;
    end
    FULL = 1'b0;
    check($sformatf("v%0d_done_in_time", idx), longint'(cyc < 3000), 1);
    repeat (3) @(negedge CLK);
    #1;
    check($sformatf("v%0d_sum", idx), SUM, v.exp_sum);
    check($sformatf("v%0d_err_cnt", idx), ERR_CNT, v.exp_err);
    check($sformatf("v%0d_writes", idx), n_wr, v.exp_wr);
    check($sformatf("v%0d_reads", idx), n_rd, v.exp_wr);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_wr_while_full", idx), full_viol, 0);
    check($sformatf("v%0d_busy_after", idx), BUSY, 0);
    if (v.exp_wr > 0) begin
      check($sformatf("v%0d_first_din", idx), first_din, v.exp_first);
      check($sformatf("v%0d_last_din", idx), last_din, v.exp_last);
    end
  endtask

  initial begin
    int w, cyc;
    //          cnt  a     b    f_at len corrupt sum    err          wr  first     last
    vecs[0] = '{4,   2,    3,   -1,  0,  -1,     68,    0,           4,  16'h0203, 16'h0506};
    vecs[1] = '{2,   255,  255, -1,  0,  -1,     65025, 0,           2,  16'hFFFF, 16'h0000};
    vecs[2] = '{16,  1,    1,   5,   10, -1,     1496,  0,           16, 16'h0101, 16'h1010};
    vecs[3] = '{0,   7,    9,   -1,  0,  -1,     0,     0,           0,  16'h0000, 16'h0000};
    vecs[4] = '{3,   1,    1,   -1,  0,  1,      15,    CORRUPT_ERR, 3,  16'h0101, 16'h0303};
    vecs[5] = '{1,   16,   16,  -1,  0,  -1,     256,   0,           1,  16'h1010, 16'h1010};
    vecs[6] = '{8,   1,    1,   -1,  0,  -1,     204,   0,           8,  16'h0101, 16'h0808};

    RST = 1'b0; START = 1'b0; FULL = 1'b0;
    COUNT = '0; A_BASE = '0; B_BASE = '0;
    EMPTY = 1'b1; VALID = 1'b0; DOUT = '0;
    repeat (3) @(negedge CLK);
    check("reset_wr", WR, 0);
    check("reset_rd", RD, 0);
    check("reset_din", DIN, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_sum", SUM, 0);
    check("reset_err_cnt", ERR_CNT, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 6; i++) run_case(i);

    // Zero length: DONE must land exactly two cycles after START.
    @(negedge CLK); #1;
    COUNT = 8'd0; START = 1'b1;
    @(negedge CLK); #1;
    START = 1'b0;
    check("zero_c1_busy", BUSY, 1);
    check("zero_c1_done", DONE, 0);
    @(negedge CLK); #1;
    check("zero_c2_done", DONE, 1);
    check("zero_c2_busy", BUSY, 0);
    @(negedge CLK); #1;
    check("zero_c3_done", DONE, 0);

    // Reset asserted during the third write of a COUNT=8 run.
    @(negedge CLK); #1;
    COUNT = 8'd8; A_BASE = 8'd1; B_BASE = 8'd1; START = 1'b1;
    @(negedge CLK); #1;
    START = 1'b0;
    w = 0; cyc = 0;
    while (w < 3 && cyc < 200) begin
      @(posedge CLK); #2;
      cyc++;
      if (WR) w++;
    end
    check("midrst_third_write", w, 3);
    RST = 1'b0;
    #1;
    check("midrst_wr", WR, 0);
    check("midrst_rd", RD, 0);
    check("midrst_din", DIN, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    check("midrst_sum", SUM, 0);
    check("midrst_err_cnt", ERR_CNT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    run_case(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
